// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states, opcodes,
// mux selects, ALU operations and the ImmSrc decode helper.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_BOOT, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_t;
  typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10} alu_src_a_t;
  typedef enum logic [1:0] {SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} alu_src_b_t;
  typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10} result_src_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011, ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} alu_op_t;

  function automatic imm_src_t imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared datapath.
interface multicycle_controller_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  ImmSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [2:0]  ALUControl;
  logic        AdrSrc;
  logic        IRWrite;
  logic        PCWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic        illegal_instr;

  modport slave (
    input  instr, zero, mem_ready,
    output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
           AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_instr
  );

  modport master (
    output instr, zero, mem_ready,
    input  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
           AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_instr
  );
endinterface

// File: rtl/alu_decoder.sv
// ALU operation decode from the FSM's ALUOp and the instruction's funct fields.
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_op_t    ALUOp,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op5) with funct7[5] set is a subtract; addi never is.
          F3_ADDSUB: ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          F3_SLT:    ALUControl = ALU_SLT;
          F3_OR:     ALUControl = ALU_OR;
          F3_AND:    ALUControl = ALU_AND;
          default:   ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RISC-V core: sequences fetch, decode and
// execute over 3-5 cycles, stalling on mem_ready for every memory access.
module multicycle_controller
  import ctrl_pkg::*;
(
  input logic                    clk,
  input logic                    rst_n,
  multicycle_controller_if.slave bus
);

  state_t      state, state_next;
  alu_op_t     alu_op;
  alu_src_a_t  alu_src_a;
  alu_src_b_t  alu_src_b;
  result_src_t result_src;
  logic        adr_src, ir_write, reg_write, mem_write, illegal;
  logic        branch, pc_update;
  logic        unused_instr_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    alu_op     = ALUOP_ADD;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    result_src = RES_ALUOUT;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    illegal    = 1'b0;
    branch     = 1'b0;
    pc_update  = 1'b0;
    unique case (state)
      S_BOOT: state_next = S_FETCH;
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (bus.mem_ready) begin
          ir_write   = 1'b1;
          pc_update  = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (bus.instr[6:0])
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECR;
          OP_IALU:      state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        state_next = bus.instr[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (bus.mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = SRCA_RD1;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RD1;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      default: state_next = S_BOOT;
    endcase
  end

  alu_decoder u_alu_decoder (
    .ALUOp      (alu_op),
    .funct3     (bus.instr[14:12]),
    .op5        (bus.instr[5]),
    .funct7b5   (bus.instr[30]),
    .ALUControl (bus.ALUControl)
  );

  assign bus.ImmSrc        = imm_src_of(bus.instr[6:0]);
  assign bus.ALUSrcA       = alu_src_a;
  assign bus.ALUSrcB       = alu_src_b;
  assign bus.ResultSrc     = result_src;
  assign bus.AdrSrc        = adr_src;
  assign bus.IRWrite       = ir_write;
  assign bus.PCWrite       = (branch & bus.zero) | pc_update;
  assign bus.RegWrite      = reg_write;
  assign bus.MemWrite      = mem_write;
  assign bus.illegal_instr = illegal;

  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed cycle table, reset corner cases and
// randomized instruction streams against a per-instruction micro-step model.
module tb_multicycle_controller;

  localparam logic [31:0] I_LW  = 32'h00452283;
  localparam logic [31:0] I_SW  = 32'h00512223;
  localparam logic [31:0] I_BEQ = 32'h00628463;
  localparam logic [31:0] I_JAL = 32'h008000EF;
  localparam logic [31:0] I_SUB = 32'h40B50533;
  localparam logic [31:0] I_ILL = 32'h0000007F;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic        mr;
    logic [16:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // Output vector order: ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
  // AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_instr.
  function automatic logic [16:0] e(input int imm, input int asa, input int asb, input int rs,
                                    input int alu, input int adr, input int irw, input int pcw,
                                    input int rw, input int mw, input int ill);
    return {2'(imm), 2'(asa), 2'(asb), 2'(rs), 3'(alu), 1'(adr), 1'(irw), 1'(pcw),
            1'(rw), 1'(mw), 1'(ill)};
  endfunction

  function automatic logic [16:0] dut_outs();
    return {bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl, bus.AdrSrc,
            bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.illegal_instr};
  endfunction

  task automatic check(input string nm, input logic [16:0] exp);
    logic [16:0] act;
    act = dut_outs();
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (imm asa asb rs alu adr irw pcw rw mw ill)", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, let them settle, compare, advance past the rising edge.
  task automatic cyc(input string nm, input logic [31:0] ins, input logic z, input logic mr,
                     input logic [16:0] exp);
    bus.instr     = ins;
    bus.zero      = z;
    bus.mem_ready = mr;
    #1;
    check(nm, exp);
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  function automatic int imm_ref(input logic [6:0] op);
    if (op == 7'h23) return 1;
    if (op == 7'h63) return 2;
    if (op == 7'h6F) return 3;
    return 0;
  endfunction

  function automatic int funct_alu(input logic [31:0] ins);
    case (ins[14:12])
      3'd0:    return (ins[5] && ins[30]) ? 1 : 0;
      3'd2:    return 5;
      3'd6:    return 3;
      3'd7:    return 2;
      default: return 0;
    endcase
  endfunction

  // Micro-step script of one instruction; its length is the unstalled latency.
  function automatic string script_of(input logic [6:0] op);
    case (op)
      7'h03:   return "FDARW";
      7'h23:   return "FDAM";
      7'h33:   return "FDXU";
      7'h13:   return "FDIU";
      7'h63:   return "FDQ";
      7'h6F:   return "FDJU";
      default: return "FD";
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F};
  endfunction

  function automatic bit waits_on_mem(input byte st);
    return st inside {"F", "R", "M"};
  endfunction

  function automatic logic [16:0] ref_outs(input byte st, input logic [31:0] ins,
                                           input logic z, input logic mr);
    int asa, asb, rs, alu, adr, irw, pcw, rw, mw, ill;
    asa = 0; asb = 0; rs = 0; alu = 0; adr = 0; irw = 0; pcw = 0; rw = 0; mw = 0; ill = 0;
    case (st)
      "F": begin asb = 2; rs = 2; irw = int'(mr); pcw = int'(mr); end
      "D": begin asa = 1; asb = 1; ill = is_legal(ins[6:0]) ? 0 : 1; end
      "A": begin asa = 2; asb = 1; end
      "R": adr = 1;
      "W": begin rs = 1; rw = 1; end
      "M": begin adr = 1; mw = 1; end
      "X": begin asa = 2; alu = funct_alu(ins); end
      "I": begin asa = 2; asb = 1; alu = funct_alu(ins); end
      "U": rw = 1;
      "Q": begin asa = 2; alu = 1; pcw = int'(z); end
      "J": begin asa = 1; asb = 2; pcw = 1; end
      default: ;
    endcase
    return e(imm_ref(ins[6:0]), asa, asb, rs, alu, adr, irw, pcw, rw, mw, ill);
  endfunction

  task automatic run_instr(input int idx, input logic [31:0] ins);
    string sc;
    byte   st;
    int    waits;
    logic  mr, z;
    sc = script_of(ins[6:0]);
    for (int i = 0; i < sc.len(); i++) begin
      st    = sc[i];
      waits = 0;
      do begin
        mr = ($urandom_range(0, 3) != 0) || (waits >= 4);
        z  = 1'($urandom_range(0, 1));
        cyc($sformatf("rnd%0d_%c%0d", idx, st, waits), ins, z, mr, ref_outs(st, ins, z, mr));
        waits++;
      end while (waits_on_mem(st) && !mr);
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[$];

  function automatic vec_t v(input logic [31:0] ins, input logic z, input logic mr,
                             input logic [16:0] exp);
    vec_t r;
    r.instr = ins; r.zero = z; r.mr = mr; r.exp = exp;
    return r;
  endfunction

  initial begin
    logic [31:0] ins;
    logic [6:0]  op;
    n_cmp  = 0;
    n_fail = 0;

    // lw with no stalls, BOOT first
    tbl.push_back(v(I_LW, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(I_LW, 0, 1, e(0, 0, 2, 2, 0, 0, 1, 1, 0, 0, 0)));
    tbl.push_back(v(I_LW, 0, 1, e(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(I_LW, 0, 1, e(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(I_LW, 0, 1, e(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(v(I_LW, 0, 1, e(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0)));
    // sw: one fetch stall, two MEMWRITE stalls
    tbl.push_back(v(I_SW, 0, 0, e(1, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(I_SW, 0, 1, e(1, 0, 2, 2, 0, 0, 1, 1, 0, 0, 0)));
    tbl.push_back(v(I_SW, 0, 1, e(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(I_SW, 0, 1, e(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(I_SW, 0, 0, e(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0)));
    tbl.push_back(v(I_SW, 0, 0, e(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0)));
    tbl.push_back(v(I_SW, 0, 1, e(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0)));
    // beq taken, then not taken
    tbl.push_back(v(I_BEQ, 1, 1, e(2, 0, 2, 2, 0, 0, 1, 1, 0, 0, 0)));
    tbl.push_back(v(I_BEQ, 1, 1, e(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(I_BEQ, 1, 1, e(2, 2, 0, 0, 1, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(v(I_BEQ, 0, 1, e(2, 0, 2, 2, 0, 0, 1, 1, 0, 0, 0)));
    tbl.push_back(v(I_BEQ, 0, 1, e(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(I_BEQ, 0, 1, e(2, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0)));
    // jal
    tbl.push_back(v(I_JAL, 0, 1, e(3, 0, 2, 2, 0, 0, 1, 1, 0, 0, 0)));
    tbl.push_back(v(I_JAL, 0, 1, e(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(I_JAL, 0, 1, e(3, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(v(I_JAL, 0, 1, e(3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)));
    // R-type sub
    tbl.push_back(v(I_SUB, 0, 1, e(0, 0, 2, 2, 0, 0, 1, 1, 0, 0, 0)));
    tbl.push_back(v(I_SUB, 0, 1, e(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(I_SUB, 1, 1, e(0, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(I_SUB, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)));
    // unsupported opcode, then back in FETCH (held once by mem_ready low)
    tbl.push_back(v(I_ILL, 0, 1, e(0, 0, 2, 2, 0, 0, 1, 1, 0, 0, 0)));
    tbl.push_back(v(I_ILL, 1, 1, e(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1)));
    tbl.push_back(v(I_SW, 0, 0, e(1, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(I_SW, 0, 1, e(1, 0, 2, 2, 0, 0, 1, 1, 0, 0, 0)));

    bus.instr     = I_LW;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset", e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    foreach (tbl[i]) cyc($sformatf("tbl%0d", i), tbl[i].instr, tbl[i].zero, tbl[i].mr, tbl[i].exp);

    // Reset mid-store: MemWrite must drop without waiting for a clock edge.
    cyc("sw_dec", I_SW, 0, 1, e(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw_adr", I_SW, 0, 1, e(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    bus.mem_ready = 1'b0;
    #1;
    check("sw_memwrite", e(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    rst_n = 1'b0;
    #1;
    check("async_reset", e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    cyc("boot_again", I_SW, 1, 1, e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0:       op = 7'h03;
        1:       op = 7'h23;
        2:       op = 7'h33;
        3:       op = 7'h13;
        4:       op = 7'h63;
        5:       op = 7'h6F;
        default: begin
          op = 7'($urandom);
          while (is_legal(op)) op = 7'($urandom);
        end
      endcase
      ins      = $urandom;
      ins[6:0] = op;
      run_instr(n, ins);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
